// File: rtl/proj_slot_pkg.sv
// Shared types and helpers for the project slot controller: FSM state encoding
// and the "no project selected" code.
package proj_slot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISOLATE = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // The "none" code is the first value past the last real slot.
    function automatic int none_code(input int num_proj);
        return num_proj;
    endfunction

endpackage

// File: rtl/proj_out_mux.sv
// Registered NUM_PROJ:1 output mux with a synchronous zero-force; owns the
// shared output bus flops.
module proj_out_mux
    import proj_slot_pkg::*;
#(
    parameter int NUM_PROJ = 8,
    parameter int SEL_BITS = 4,
    parameter int OUT_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SEL_BITS-1:0]          sel,
    input  logic                         zero,
    input  logic [NUM_PROJ*OUT_BITS-1:0] proj_out,
    output logic [OUT_BITS-1:0]          out
);

    logic [OUT_BITS-1:0] slot [NUM_PROJ];
    logic [OUT_BITS-1:0] picked;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PROJ; gi++) begin : g_slot
            assign slot[gi] = proj_out[gi*OUT_BITS +: OUT_BITS];
        end
    endgenerate

    // Out-of-range selects fall through to zero.
    always_comb begin
        picked = '0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            if (sel == SEL_BITS'(i)) begin
                picked = slot[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (zero) begin
            out <= '0;
        end else begin
            out <= picked;
        end
    end

endmodule

// File: rtl/proj_slot_ctrl.sv
// Shares the single user I/O slot among NUM_PROJ projects, sequencing each
// selected project through isolate, held reset and run.
module proj_slot_ctrl
    import proj_slot_pkg::*;
#(
    parameter int NUM_PROJ   = 8,
    parameter int SEL_BITS   = 4,
    parameter int OUT_BITS   = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    input  logic [SEL_BITS-1:0]          cfg_sel,
    output logic                         cfg_ready,
    input  logic [NUM_PROJ*OUT_BITS-1:0] proj_out,
    output logic [NUM_PROJ-1:0]          proj_en,
    output logic [NUM_PROJ-1:0]          proj_rst_n,
    output logic [OUT_BITS-1:0]          out,
    output logic [SEL_BITS-1:0]          active_sel,
    output logic                         running
);

    localparam logic [SEL_BITS-1:0] NONE = SEL_BITS'(none_code(NUM_PROJ));
    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

    state_t              state_reg, state_next;
    logic [SEL_BITS-1:0] target_reg, target_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [SEL_BITS-1:0] req_sel;
    logic                accept;
    logic                live;
    logic                out_zero;

    assign req_sel = (cfg_sel >= NONE) ? NONE : cfg_sel;
    assign accept  = cfg_valid && cfg_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            target_reg <= NONE;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    target_next = req_sel;
                    if (req_sel != NONE) begin
                        state_next = ST_ISOLATE;
                    end
                end
            end
            ST_ISOLATE: begin
                if (target_reg != NONE) begin
                    state_next = ST_HOLD;
                    cnt_next   = CNT_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_RUN: begin
                // Reselecting the running slot still goes through isolate (soft reset).
                if (accept) begin
                    target_next = req_sel;
                    state_next  = ST_ISOLATE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign live      = (state_reg == ST_HOLD) || (state_reg == ST_RUN);
    assign running   = (state_reg == ST_RUN);
    assign cfg_ready = (state_reg == ST_IDLE) || (state_reg == ST_RUN);
    assign active_sel = live ? target_reg : NONE;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PROJ; gi++) begin : g_proj
            assign proj_en[gi]    = live && (target_reg == SEL_BITS'(gi));
            assign proj_rst_n[gi] = running && (target_reg == SEL_BITS'(gi));
        end
    endgenerate

    // Capture only on edges that both start and end in RUN, so the first
    // capture is one edge after entering RUN and isolate always shows zero.
    assign out_zero = !(running && (state_next == ST_RUN));

    proj_out_mux #(
        .NUM_PROJ (NUM_PROJ),
        .SEL_BITS (SEL_BITS),
        .OUT_BITS (OUT_BITS)
    ) u_out_mux (
        .clk      (clk),
        .rst      (rst),
        .sel      (target_reg),
        .zero     (out_zero),
        .proj_out (proj_out),
        .out      (out)
    );

endmodule
